instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-word fetches and drives the IF/ID register.
// A response that arrives while decode is stalled is parked in hold_buf so the word is never refetched.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid
);

  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_buf_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH) && !reset;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      hold_buf_q <= '0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
    end else if (branch_taken) begin
      // Masking keeps the redirect word-aligned regardless of the target's low bits.
      state_q    <= FETCH;
      pc_q       <= branch_target & ~32'h0000_0003;
      hold_buf_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (flush) begin
      state_q    <= FETCH;
      hold_buf_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              hold_buf_q <= imem_rdata;
              state_q    <= HOLD;
            end else begin
              instr_q  <= imem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + 32'd4;
            end
          end else if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_q  <= hold_buf_q;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + 32'd4;
            state_q  <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a word-delivery reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset, stall, flush, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid;
  logic [31:0] imem_addr, instruction, pc_out;
  logic        w_imem_req, w_valid;
  logic [31:0] w_imem_addr, w_instruction, w_pc_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .valid(valid)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(w_instruction), .pc_out(w_pc_out), .valid(w_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the PC, whether a fetched word is waiting out a stall, and the IF/ID contents.
  logic [31:0] m_pc    = 32'h0;
  logic        m_held  = 1'b0;
  logic [31:0] m_buf   = 32'h0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcout = 32'h0;
  logic        m_valid = 1'b0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic st, input logic fl, input logic bt,
                            input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    logic        have;
    logic [31:0] word;
    if (r) begin
      m_pc = 32'h0; m_held = 1'b0; m_buf = 32'h0;
      m_instr = NOP; m_pcout = 32'h0; m_valid = 1'b0;
    end else if (bt) begin
      m_pc = {tgt[31:2], 2'b00}; m_held = 1'b0;
      m_instr = NOP; m_valid = 1'b0;
    end else if (fl) begin
      m_held = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else begin
      have = m_held || rdy;
      word = m_held ? m_buf : rd;
      if (st) begin
        if (!m_held && rdy) begin
          m_held = 1'b1; m_buf = rd;
        end
      end else if (have) begin
        m_instr = word; m_pcout = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, check fetch request, clock the edge, check IF/ID.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic bt,
                     input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    reset = r; stall = st; flush = fl; branch_taken = bt;
    branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, (!r && !m_held)});
    if (!r) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_edge(r, st, fl, bt, tgt, rdy, rd);
    @(negedge clk);
    chk("instruction", instruction, m_instr);
    chk("pc_out", pc_out, m_pcout);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
  endtask

  initial begin
    logic r, st, fl, bt, rdy;
    logic [31:0] tgt, rd;
    @(negedge clk);

    // Reset, with a stray response that must be ignored.
    cyc(1, 0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    cyc(1, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);

    // Zero-wait stream from 0; also checks the wrapping instance's first two fetches.
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h0));
    chk("wrap_instr", w_instruction, memw(32'h0));
    chk("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap_next_addr", w_imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h4));

    // Two wait states at pc=8, then the word arrives.
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h8));
    chk("pc_out_after_wait", pc_out, 32'h8);

    // Word@12 returns under stall, held for three cycles, then released.
    cyc(0, 1, 0, 0, 32'h0, 1, memw(32'hC));
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("held_word", instruction, memw(32'hC));

    // Flush at pc=16 while its word returns; the word is refetched.
    cyc(0, 0, 1, 0, 32'h0, 1, memw(32'h10));
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h10));
    chk("refetch_pc", pc_out, 32'h10);

    // Redirect while in HOLD with stall asserted; the held word must not reappear.
    cyc(0, 1, 0, 0, 32'h0, 1, memw(32'h14));
    cyc(0, 1, 0, 1, 32'h103, 0, 32'h0);
    chk("redirect_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h100));

    // Reset arriving mid-HOLD.
    cyc(0, 1, 0, 0, 32'h0, 1, memw(32'h104));
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 1, memw(32'h0));

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      bt  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      tgt = $urandom();
      rd  = rdy ? memw(m_pc) : $urandom();
      cyc(r, st, fl, bt, tgt, rdy, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
